// File: rtl/datapath_control_seq_pkg.sv
// Shared definitions for the datapath control sequencer: state encoding,
// opcode values, IR field positions and opcode classification.
package ctrl_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_T0        = 4'd1,
    ST_T1        = 4'd2,
    ST_T2        = 4'd3,
    ST_T3        = 4'd4,
    ST_T4        = 4'd5,
    ST_T5        = 4'd6,
    ST_T6        = 4'd7,
    ST_HALT      = 4'd8,
    ST_STEP_WAIT = 4'd9
  } state_e;

  localparam int OPC_W     = 5;
  localparam int REG_IDX_W = 4;
  localparam int IR_OP_LSB = 27;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_LSB = 15;

  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPC_W-1:0] OP_SHL  = 5'b01000;
  localparam logic [OPC_W-1:0] OP_ROR  = 5'b01001;
  localparam logic [OPC_W-1:0] OP_ROL  = 5'b01010;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'b01110;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OPC_W-1:0] OP_NEG  = 5'b10000;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'b10001;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

  function automatic logic is_binary(input logic [OPC_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL: is_binary = 1'b1;
      default: is_binary = 1'b0;
    endcase
  endfunction

  function automatic logic is_muldiv(input logic [OPC_W-1:0] op);
    case (op)
      OP_MUL, OP_DIV: is_muldiv = 1'b1;
      default:        is_muldiv = 1'b0;
    endcase
  endfunction

  function automatic logic is_unary(input logic [OPC_W-1:0] op);
    case (op)
      OP_NEG, OP_NOT: is_unary = 1'b1;
      default:        is_unary = 1'b0;
    endcase
  endfunction

  function automatic logic is_defined(input logic [OPC_W-1:0] op);
    is_defined = is_binary(op) | is_muldiv(op) | is_unary(op) | (op == OP_HALT);
  endfunction

endpackage

// File: rtl/datapath_control_seq_reg_sel_decoder.sv
// Register index to one-hot select; mask_r0 suppresses R0 so it can never be written.
module reg_sel_decoder
  import ctrl_seq_pkg::*;
(
  input  logic [REG_IDX_W-1:0] idx,
  input  logic                 en,
  input  logic                 mask_r0,
  output logic [15:0]          onehot
);

  logic [15:0] sel_s;

  // one-hot decode then optional R0 mask
  always_comb begin
    sel_s  = 16'h0000;
    if (en) begin
      sel_s = 16'h0001 << idx;
    end else begin
      sel_s = 16'h0000;
    end
    onehot = sel_s & {15'h7fff, ~mask_r0};
  end

endmodule

// File: rtl/datapath_control_seq.sv
// Moore control sequencer for the single-bus datapath (fetch T0-T2, execute T3-T6).
// Optional SEQ_SINGLE_STEP_EN adds a step input and parks in STEP_WAIT after each instruction.
module datapath_control_seq
  import ctrl_seq_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int OP_W     = 5
) (
  input  logic            clk,
  input  logic            clr,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic            step,
`endif
  input  logic            start,
  input  logic [31:0]     ir,
  output logic            PCout,
  output logic            MDRout,
  output logic            ZLowout,
  output logic            ZHighout,
  output logic            MARin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            ZLowIn,
  output logic            ZHighIn,
  output logic            HIin,
  output logic            LOin,
  output logic            IncPC,
  output logic            Read,
  output logic [15:0]     r_out,
  output logic [15:0]     r_in,
  output logic [OP_W-1:0] operation,
  output logic            busy,
  output logic            halted,
  output logic            illegal
);

  // A zero wait is treated as one; the counter is 4 bits so the ceiling is 15.
  localparam logic [3:0] WAIT_LAST = (MEM_WAIT <= 1) ? 4'd0 :
                                     (MEM_WAIT >= 15) ? 4'd14 : 4'(MEM_WAIT - 1);

`ifdef SEQ_SINGLE_STEP_EN
  localparam state_e END_STATE = ST_STEP_WAIT;
`else
  localparam state_e END_STATE = ST_T0;
`endif

  state_e                 state_r, state_s;
  logic [3:0]             wait_cnt_r;
  logic [OP_W-1:0]        op_r;
  logic [REG_IDX_W-1:0]   ra_r, rb_r, rc_r;
  logic                   illegal_r;
  logic                   r_out_en_s, r_in_en_s;
  logic [REG_IDX_W-1:0]   r_out_idx_s;
  logic                   unused_ir_s;

  assign unused_ir_s = ^ir[14:0];
  assign illegal     = illegal_r;

  // state register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // memory wait counter, cleared whenever we are not in T1
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wait_cnt_r <= 4'd0;
    end else if (state_r == ST_T1) begin
      wait_cnt_r <= wait_cnt_r + 4'd1;
    end else begin
      wait_cnt_r <= 4'd0;
    end
  end

  // IR fields captured as IR loads at the end of T2
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      op_r <= {OP_W{1'b0}};
      ra_r <= 4'd0;
      rb_r <= 4'd0;
      rc_r <= 4'd0;
    end else if (state_r == ST_T2) begin
      op_r <= ir[IR_OP_LSB +: OP_W];
      ra_r <= ir[IR_RA_LSB +: REG_IDX_W];
      rb_r <= ir[IR_RB_LSB +: REG_IDX_W];
      rc_r <= ir[IR_RC_LSB +: REG_IDX_W];
    end else begin
      op_r <= op_r;
      ra_r <= ra_r;
      rb_r <= rb_r;
      rc_r <= rc_r;
    end
  end

  // sticky undefined-opcode flag
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      illegal_r <= 1'b0;
    end else if ((state_r == ST_T3) && !is_defined(op_r)) begin
      illegal_r <= 1'b1;
    end else begin
      illegal_r <= illegal_r;
    end
  end

  // next-state and Moore output decode
  always_comb begin
    state_s     = state_r;
    PCout       = 1'b0;  MDRout  = 1'b0;  ZLowout = 1'b0;  ZHighout = 1'b0;
    MARin       = 1'b0;  MDRin   = 1'b0;  IRin    = 1'b0;  Yin      = 1'b0;
    ZLowIn      = 1'b0;  ZHighIn = 1'b0;  HIin    = 1'b0;  LOin     = 1'b0;
    IncPC       = 1'b0;  Read    = 1'b0;
    operation   = {OP_W{1'b0}};
    r_out_en_s  = 1'b0;
    r_out_idx_s = rb_r;
    r_in_en_s   = 1'b0;
    busy        = 1'b1;
    halted      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_s = ST_T0;
        else       state_s = ST_IDLE;
      end
      ST_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1;
        state_s = ST_T1;
      end
      ST_T1: begin
        Read = 1'b1; MDRin = 1'b1;
        if (wait_cnt_r >= WAIT_LAST) state_s = ST_T2;
        else                         state_s = ST_T1;
      end
      ST_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_s = ST_T3;
      end
      ST_T3: begin
        if (is_unary(op_r)) begin
          r_out_en_s = 1'b1; operation = op_r; ZLowIn = 1'b1;
          state_s = ST_T4;
        end else if (is_binary(op_r) || is_muldiv(op_r)) begin
          r_out_en_s = 1'b1; Yin = 1'b1;
          state_s = ST_T4;
        end else begin
          state_s = ST_HALT;
        end
      end
      ST_T4: begin
        if (is_unary(op_r)) begin
          ZLowout = 1'b1; r_in_en_s = 1'b1;
          state_s = END_STATE;
        end else begin
          r_out_en_s = 1'b1; r_out_idx_s = rc_r; operation = op_r;
          ZLowIn = 1'b1; ZHighIn = is_muldiv(op_r);
          state_s = ST_T5;
        end
      end
      ST_T5: begin
        ZLowout = 1'b1;
        if (is_muldiv(op_r)) begin
          LOin = 1'b1;
          state_s = ST_T6;
        end else begin
          r_in_en_s = 1'b1;
          state_s = END_STATE;
        end
      end
      ST_T6: begin
        ZHighout = 1'b1; HIin = 1'b1;
        state_s = END_STATE;
      end
      ST_HALT: begin
        busy = 1'b0; halted = 1'b1;
        state_s = ST_HALT;
      end
      ST_STEP_WAIT: begin
        busy = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        if (step) state_s = ST_T0;
        else      state_s = ST_STEP_WAIT;
`else
        state_s = ST_IDLE;
`endif
      end
      default: begin
        busy = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  reg_sel_decoder u_r_out_dec (
    .idx     (r_out_idx_s),
    .en      (r_out_en_s),
    .mask_r0 (1'b0),
    .onehot  (r_out)
  );

  reg_sel_decoder u_r_in_dec (
    .idx     (ra_r),
    .en      (r_in_en_s),
    .mask_r0 (1'b1),
    .onehot  (r_in)
  );

endmodule
